// File: rtl/unidad_control_multiciclo_if.sv
// Control bus between the multicycle control unit and the RV32I datapath.
// master = control unit side, slave = datapath side.
interface unidad_control_multiciclo_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       PCWrite;
   logic       AdrSrc;
   logic       IRWrite;
   logic       MemWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUControl;
   logic [1:0] ImmSrc;
   logic       instr_done;
   logic       illegal;
   logic [3:0] state_dbg;

   modport master (
      input  op, funct3, funct7b5, zero,
      output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, illegal, state_dbg
   );

   modport slave (
      output op, funct3, funct7b5, zero,
      input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, illegal, state_dbg
   );
endinterface

// File: rtl/unidad_control_multiciclo.sv
// Multicycle control FSM for the RV32I subset datapath (lw/sw/R/I/beq/jal).
// Moore control vector per state; PCWrite folds in zero, ImmSrc decodes op directly.
module unidad_control_multiciclo (
   input  logic                          clk,
   input  logic                          rst_n,
   unidad_control_multiciclo_if.master   bus
);
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10,
      TRAP     = 4'd11
   } state_t;

   state_t     state, state_next;
   logic       illegal_q;

   logic       pc_update, branch, adr_src, ir_write, mem_write, reg_write, done;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_control;
   logic       f3_ok;
   logic [1:0] alu_fn;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= FETCH;
         illegal_q <= 1'b0;
      end else begin
         state <= state_next;
         if (state_next == TRAP)
            illegal_q <= 1'b1;
      end
   end

   // ALU function for EXECR/EXECI; subtract only for R-type with funct7b5
   always_comb begin
      f3_ok  = 1'b1;
      alu_fn = 2'b00;
      case (bus.funct3)
         3'b000:  alu_fn = (state == EXECR && bus.funct7b5) ? 2'b01 : 2'b00;
         3'b111:  alu_fn = 2'b10;
         3'b110:  alu_fn = 2'b11;
         default: f3_ok  = 1'b0;
      endcase
   end

   always_comb begin
      state_next  = FETCH;
      pc_update   = 1'b0;
      branch      = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      done        = 1'b0;
      result_src  = '0;
      alu_src_a   = '0;
      alu_src_b   = '0;
      alu_control = '0;
      case (state)
         FETCH: begin
            ir_write   = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            pc_update  = 1'b1;
            state_next = DECODE;
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (bus.op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_R:         state_next = EXECR;
               OP_I:         state_next = EXECI;
               OP_BEQ:       state_next = BEQ;
               OP_JAL:       state_next = JAL;
               default:      state_next = TRAP;
            endcase
         end
         MEMADR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            state_next = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adr_src    = 1'b1;
            state_next = MEMWB;
         end
         MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            done       = 1'b1;
         end
         MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            done      = 1'b1;
         end
         EXECR, EXECI: begin
            alu_src_a   = 2'b10;
            alu_src_b   = (state == EXECI) ? 2'b01 : 2'b00;
            alu_control = alu_fn;
            state_next  = f3_ok ? ALUWB : TRAP;
         end
         ALUWB: begin
            reg_write = 1'b1;
            done      = 1'b1;
         end
         BEQ: begin
            alu_src_a   = 2'b10;
            alu_control = 2'b01;
            branch      = 1'b1;
            done        = 1'b1;
         end
         JAL: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            pc_update  = 1'b1;
            state_next = ALUWB;
         end
         TRAP:    state_next = TRAP;
         default: state_next = FETCH;
      endcase
   end

   // Write enables and done are masked while reset is held so nothing commits.
   assign bus.PCWrite    = rst_n & (pc_update | (branch & bus.zero));
   assign bus.IRWrite    = rst_n & ir_write;
   assign bus.MemWrite   = rst_n & mem_write;
   assign bus.RegWrite   = rst_n & reg_write;
   assign bus.instr_done = rst_n & done;
   assign bus.AdrSrc     = adr_src;
   assign bus.ResultSrc  = result_src;
   assign bus.ALUSrcA    = alu_src_a;
   assign bus.ALUSrcB    = alu_src_b;
   assign bus.ALUControl = alu_control;
   assign bus.illegal    = illegal_q;
   assign bus.state_dbg  = state;

   always_comb begin
      case (bus.op)
         OP_SW:   bus.ImmSrc = 2'b01;
         OP_BEQ:  bus.ImmSrc = 2'b10;
         OP_JAL:  bus.ImmSrc = 2'b11;
         default: bus.ImmSrc = 2'b00;
      endcase
   end
endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Scoreboard bench for unidad_control_multiciclo: directed test-plan program followed
// by random instructions; expected per-cycle control vectors and latencies are queued.
module tb_unidad_control_multiciclo;
   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BQ  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;

   typedef struct {
      int          kind;   // 0 normal cycle, 1 reset (enables only), 2 reset after an edge
      int          st;
      logic [16:0] vec;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   unidad_control_multiciclo_if bus ();

   unidad_control_multiciclo dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   exp_t cyc_q[$];
   int   done_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   lat      = 0;
   logic illegal_m = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got 0x%0h, required 0x%0h", name, cyc, act, req);
      end
   endtask

   function automatic logic [1:0] alu_of(input logic [2:0] f3, input logic sub_ok);
      if (f3 == 3'd0) return sub_ok ? 2'b01 : 2'b00;
      if (f3 == 3'd7) return 2'b10;
      if (f3 == 3'd6) return 2'b11;
      return 2'b00;
   endfunction

   // Control table taken state by state from the instruction set behaviour
   function automatic logic [16:0] mk(input int st, input logic [6:0] o, input logic [2:0] f3,
                                      input logic f7, input logic z, input logic ill);
      logic irw = 0, mw = 0, rw = 0, pcw = 0, adr = 0, dn = 0;
      logic [1:0] rs = 0, sa = 0, sb = 0, alu = 0, imm;
      imm = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
      case (st)
         0:  begin irw = 1; sb = 2; rs = 2; pcw = 1; end
         1:  begin sa = 1; sb = 1; end
         2:  begin sa = 2; sb = 1; end
         3:  adr = 1;
         4:  begin rs = 1; rw = 1; dn = 1; end
         5:  begin adr = 1; mw = 1; dn = 1; end
         6:  begin sa = 2; sb = 0; alu = alu_of(f3, f7); end
         7:  begin sa = 2; sb = 1; alu = alu_of(f3, 1'b0); end
         8:  begin rw = 1; dn = 1; end
         9:  begin sa = 2; alu = 1; pcw = z; dn = 1; end
         10: begin sa = 1; sb = 2; pcw = 1; end
         default: ;
      endcase
      return {irw, mw, rw, pcw, adr, dn, ill, rs, sa, sb, alu, imm};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         rst_n = 1'b0;
         cyc_q.push_back('{kind: (i == 0) ? 1 : 2, st: 0, vec: '0});
         step();
      end
      illegal_m = 1'b0;
   endtask

   task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic zb, input int abort_at);
      int   path[$];
      logic good_f3 = (f3 == 3'd0) || (f3 == 3'd7) || (f3 == 3'd6);
      logic z;
      bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7;
      case (o)
         LW:      path = '{0, 1, 2, 3, 4};
         SW:      path = '{0, 1, 2, 5};
         RT:      path = good_f3 ? '{0, 1, 6, 8} : '{0, 1, 6, 11};
         IT:      path = good_f3 ? '{0, 1, 7, 8} : '{0, 1, 7, 11};
         BQ:      path = '{0, 1, 9};
         JL:      path = '{0, 1, 10, 8};
         default: path = '{0, 1, 11};
      endcase
      if (path[path.size()-1] == 11)
         for (int i = 0; i < 9; i++) path.push_back(11);
      else if (abort_at < 0)
         done_q.push_back(path.size());
      foreach (path[i]) begin
         if (i == abort_at) begin
            do_reset(1);
            return;
         end
         rst_n = 1'b1;
         z = (path[i] == 9) ? zb : 1'($urandom_range(0, 1));
         bus.zero = z;
         if (path[i] == 11) illegal_m = 1'b1;
         cyc_q.push_back('{kind: 0, st: path[i], vec: mk(path[i], o, f3, f7, z, illegal_m)});
         step();
      end
      if (path[path.size()-1] == 11) do_reset(1);
   endtask

   // Monitor: per-cycle vector compare, and latency compare on each retirement
   initial begin
      exp_t e;
      logic [16:0] v;
      forever begin
         @(negedge clk);
         cyc++;
         v = {bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.PCWrite, bus.AdrSrc, bus.instr_done,
              bus.illegal, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc};
         if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            if (e.kind == 0) begin
               chk($sformatf("state_dbg exp_st=%0d", e.st), 32'(bus.state_dbg), 32'(e.st));
               chk($sformatf("ctrl_vec st=%0d", e.st), 32'(v), 32'(e.vec));
            end else begin
               chk("enables_in_reset", 32'({bus.IRWrite, bus.MemWrite, bus.RegWrite,
                                           bus.PCWrite, bus.instr_done}), 32'd0);
               if (e.kind == 2) begin
                  chk("state_in_reset", 32'(bus.state_dbg), 32'd0);
                  chk("illegal_in_reset", 32'(bus.illegal), 32'd0);
               end
            end
         end
         if (!rst_n) lat = 0;
         else if (bus.state_dbg == 4'd0) lat = 1;
         else lat++;
         if (rst_n && bus.instr_done) begin
            if (done_q.size() == 0) chk("unexpected_instr_done", 32'd1, 32'd0);
            else chk("latency", 32'(lat), 32'(done_q.pop_front()));
         end
      end
   end

   initial begin
      logic [6:0] o;
      logic [2:0] f3;
      int         k;
      bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
      step();
      do_reset(3);
      issue(IT, 3'b000, 1'b0, 1'b0, -1);    // addi x1,x0,5
      issue(RT, 3'b000, 1'b0, 1'b0, -1);    // add
      issue(RT, 3'b000, 1'b1, 1'b0, -1);    // sub
      issue(SW, 3'b010, 1'b0, 1'b0, -1);
      issue(LW, 3'b010, 1'b0, 1'b0, -1);
      issue(BQ, 3'b000, 1'b0, 1'b1, -1);
      issue(BQ, 3'b000, 1'b0, 1'b0, -1);
      issue(JL, 3'b000, 1'b0, 1'b0, -1);
      issue(7'h7F, 3'b000, 1'b0, 1'b0, -1);
      issue(IT, 3'b111, 1'b0, 1'b0, -1);    // andi after trap recovery
      issue(LW, 3'b010, 1'b0, 1'b0, 3);     // reset lands on MEMREAD
      issue(RT, 3'b110, 1'b0, 1'b0, -1);
      issue(RT, 3'b001, 1'b0, 1'b0, -1);    // unsupported funct3
      for (int n = 0; n < 60; n++) begin
         k = $urandom_range(0, 7);
         case (k)
            0: o = LW;  1: o = SW;  2, 3: o = RT;  4: o = IT;  5: o = BQ;  6: o = JL;
            default: begin
               do o = 7'($urandom_range(0, 127));
               while (o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL);
            end
         endcase
         f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7))
                                          : ((k == 2) ? 3'd0 : 3'($urandom_range(6, 7)));
         issue(o, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
      end
      rst_n = 1'b1;
      step();
      chk("cycle_queue_drained", 32'(cyc_q.size()), 32'd0);
      chk("done_queue_drained", 32'(done_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
